reaction_game_fsm: RTL and testbench
====================================

Name: reaction_game_fsm

Overview:
- Game-flow controller for the reaction-time benchmark. It sits directly upstream of the VGA control stage.
- Converts the player's key presses into the screen selector and a millisecond reaction score, which the VGA stage renders as a blue, red, green or score background with 4 score digits.
- Owns the random red-phase delay, the millisecond timebase and score saturation.

Parameters:
- TICKS_PER_MS, 50000, clk cycles per millisecond tick (50 MHz clock).
- MIN_DELAY_MS, 1000, minimum red-phase duration in ms.
- RAND_BITS, 11, LFSR bits added to the delay; red-phase range is MIN_DELAY_MS .. MIN_DELAY_MS+2^RAND_BITS-1.
- LFSR_SEED, 16'hACE1, non-zero LFSR reset value.

Ports:
- clk  in  1  system clock
- iReset  in  1  synchronous, active-high reset
- keyPress  in  1  player key level, active-high, already synchronised and debounced
- reactScreen  out  2  0 = blue idle, 1 = red wait, 2 = green go, 3 = score
- currentScore  out  12  last reaction time in ms, 0..4095
- attemptDone  out  1  1-cycle pulse when a score is latched
- falseStart  out  1  1-cycle pulse on a press during red

Behaviour:
- Reset values: state IDLE, reactScreen=0, currentScore=0, attemptDone=0, falseStart=0.
  - keyPrev=1, so a key held through reset is not a press.
  - LFSR=LFSR_SEED; prescaler=0; msCount=0.
- Press detection:
  - press = keyPress & ~keyPrev; keyPrev registers keyPress every cycle.
  - One press per rising edge; a held key never repeats.
- LFSR: 16-bit Galois, taps x^16+x^14+x^13+x^11+1, advances every cycle (including in IDLE).
- Prescaler:
  - Counts 0..TICKS_PER_MS-1; msTick is asserted when it equals TICKS_PER_MS-1, then it wraps.
  - Cleared on entry to WAIT and GO, so the first tick falls TICKS_PER_MS cycles after entry.
- reactScreen is driven directly from the state register: IDLE=0, WAIT=1, GO=2, SCORE=3. It changes in the cycle after the press edge is sampled (1-cycle latency).
- IDLE:
  - On press, load msCount = MIN_DELAY_MS + LFSR[RAND_BITS-1:0] and go to WAIT.
- WAIT:
  - On msTick, decrement msCount.
  - When msTick occurs with msCount==1, go to GO and clear msCount to 0.
  - On press, go to IDLE and pulse falseStart; currentScore is unchanged.
  - If press and expiry happen in the same cycle, press wins: false start.
- GO:
  - On msTick, msCount++.
  - On press, currentScore <= msCount (value before any same-cycle increment), pulse attemptDone, go to SCORE.
  - If msTick occurs with msCount==4095 and no press: currentScore <= 4095, pulse attemptDone, go to SCORE (saturation / timeout).
- SCORE:
  - Hold currentScore.
  - On press, go to IDLE.
- currentScore changes only on a latch in GO or on reset. It is never cleared when a new attempt starts.
- Width rule: msCount is 12 bits. MIN_DELAY_MS + 2^RAND_BITS - 1 must be ≤ 4095; this is checked by an elaboration-time assertion.
- Reset mid-operation (any state) returns to IDLE on the next edge with all reset values. A pulse in flight is dropped.

Optional Feature:
- Macro: BEST_SCORE_EN.
- Defined:
  - Adds output port bestScore[11:0], reset to 4095.
  - On each attemptDone, bestScore <= min(bestScore, latched score).
  - False starts never update bestScore.
- Undefined:
  - Port and register are absent; all other behaviour is identical.

Test Plan:
All scenarios use TICKS_PER_MS=4, MIN_DELAY_MS=2, RAND_BITS=2, LFSR_SEED=16'hACE1.
1. Reset with keyPress held high, then hold 10 cycles -> reactScreen stays 0, no pulses. Release, then press -> reactScreen=1 one cycle later.
2. Full attempt: press in IDLE, wait for reactScreen=2, press after exactly 37 ms ticks -> currentScore=37, attemptDone high for 1 cycle, reactScreen=3. Press again -> reactScreen=0, currentScore still 37.
3. False start: press in IDLE, then press again 3 cycles later (still red) -> falseStart 1-cycle pulse, reactScreen=0, currentScore unchanged. A press in the same cycle as delay expiry also yields a false start.
4. Timeout: enter GO and never press -> after 4096 ticks (16384 cycles), currentScore=4095, attemptDone pulse, reactScreen=3.
5. Delay range: run 50 attempts, record cycles spent in WAIT -> each is within 2..5 ms (8..20 cycles plus the entry offset), and at least 2 distinct values occur.
6. With BEST_SCORE_EN: scores 120, 85, false start, 300 -> bestScore 4095→120→85→85→85. Then apply iReset mid-GO -> bestScore=4095, reactScreen=0.

Source files
------------

// File: rtl/reaction_game_fsm_if.sv
`default_nettype none
// ============================================================================
// Module      : reaction_game_fsm_if
// Description : Player/screen signal bundle between the reaction-game
//               controller (slave) and its environment (master).
//               BEST_SCORE_EN adds the bestScore output.
// Revision    : 1.0 - initial release
// ============================================================================
interface reaction_game_fsm_if;
    logic        keyPress;
    logic [1:0]  reactScreen;
    logic [11:0] currentScore;
    logic        attemptDone;
    logic        falseStart;
`ifdef BEST_SCORE_EN
    logic [11:0] bestScore;

    modport master (output keyPress,
                    input  reactScreen, currentScore, attemptDone, falseStart, bestScore);
    modport slave  (input  keyPress,
                    output reactScreen, currentScore, attemptDone, falseStart, bestScore);
`else
    modport master (output keyPress,
                    input  reactScreen, currentScore, attemptDone, falseStart);
    modport slave  (input  keyPress,
                    output reactScreen, currentScore, attemptDone, falseStart);
`endif
endinterface
`default_nettype wire

// File: rtl/reaction_game_fsm.sv
`default_nettype none
// ============================================================================
// Module      : reaction_game_fsm
// Description : Reaction-time game flow controller. Turns key presses into
//               the screen selector and a millisecond reaction score, with a
//               random red-phase delay and score saturation at 4095 ms.
//               Optional macro BEST_SCORE_EN adds a best-score tracker.
// Revision    : 1.0 - initial release
// ============================================================================
module reaction_game_fsm #(
    parameter int          TICKS_PER_MS = 50000,
    parameter int          MIN_DELAY_MS = 1000,
    parameter int          RAND_BITS    = 11,
    parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
    input  wire logic            clk,
    input  wire logic            iReset,
    reaction_game_fsm_if.slave   io_game
);

    localparam int             PS_W      = (TICKS_PER_MS > 1) ? $clog2(TICKS_PER_MS) : 1;
    localparam logic [PS_W-1:0] c_PS_LAST = PS_W'(TICKS_PER_MS - 1);
    localparam logic [15:0]    c_TAPS    = 16'hB400; // x^16+x^14+x^13+x^11+1
    localparam logic [11:0]    c_MS_MAX  = 12'hFFF;

    // The longest red phase must fit in the 12-bit millisecond counter.
    generate
        if (MIN_DELAY_MS + (2 ** RAND_BITS) - 1 > 4095) begin : g_range_check
            $error("reaction_game_fsm: MIN_DELAY_MS + 2**RAND_BITS - 1 exceeds 4095");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_GO    = 2'd2,
        S_SCORE = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_key_prev;
    logic [15:0]       r_lfsr;
    logic [PS_W-1:0]   r_prescale;
    logic [11:0]       r_ms_count;
    logic [11:0]       r_score;
    logic              r_done;
    logic              r_false;

    logic              w_press;
    logic              w_ms_tick;
    logic              w_ps_clr;
    logic [11:0]       w_ms_nxt;
    logic [11:0]       w_score_nxt;
    logic              w_done_nxt;
    logic              w_false_nxt;

    assign w_press   = io_game.keyPress & ~r_key_prev;
    assign w_ms_tick = (r_prescale == c_PS_LAST);

    // Edge detector history and free-running Galois LFSR.
    always_ff @(posedge clk) begin
        if (iReset) begin
            r_key_prev <= 1'b1;
            r_lfsr     <= LFSR_SEED;
        end else begin
            r_key_prev <= io_game.keyPress;
            r_lfsr     <= {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? c_TAPS : 16'h0000);
        end
    end

    // Millisecond prescaler, restarted on phase entry so timing is entry-relative.
    always_ff @(posedge clk) begin
        if (iReset) begin
            r_prescale <= '0;
        end else if (w_ps_clr || w_ms_tick) begin
            r_prescale <= '0;
        end else begin
            r_prescale <= r_prescale + PS_W'(1);
        end
    end

    // State, millisecond counter, score and pulse registers.
    always_ff @(posedge clk) begin
        if (iReset) begin
            r_state    <= S_IDLE;
            r_ms_count <= 12'd0;
            r_score    <= 12'd0;
            r_done     <= 1'b0;
            r_false    <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_ms_count <= w_ms_nxt;
            r_score    <= w_score_nxt;
            r_done     <= w_done_nxt;
            r_false    <= w_false_nxt;
        end
    end

    // Next-state logic; a press always takes priority over a same-cycle tick.
    always_comb begin
        w_state_nxt = r_state;
        w_ms_nxt    = r_ms_count;
        w_score_nxt = r_score;
        w_done_nxt  = 1'b0;
        w_false_nxt = 1'b0;
        w_ps_clr    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_press) begin
                    w_ms_nxt    = 12'(MIN_DELAY_MS) + 12'(r_lfsr[RAND_BITS-1:0]);
                    w_state_nxt = S_WAIT;
                    w_ps_clr    = 1'b1;
                end
            end
            S_WAIT: begin
                if (w_press) begin
                    w_state_nxt = S_IDLE;
                    w_false_nxt = 1'b1;
                end else if (w_ms_tick) begin
                    if (r_ms_count == 12'd1) begin
                        w_state_nxt = S_GO;
                        w_ms_nxt    = 12'd0;
                        w_ps_clr    = 1'b1;
                    end else begin
                        w_ms_nxt = r_ms_count - 12'd1;
                    end
                end
            end
            S_GO: begin
                if (w_press) begin
                    w_score_nxt = r_ms_count;
                    w_done_nxt  = 1'b1;
                    w_state_nxt = S_SCORE;
                end else if (w_ms_tick) begin
                    if (r_ms_count == c_MS_MAX) begin
                        w_score_nxt = c_MS_MAX;
                        w_done_nxt  = 1'b1;
                        w_state_nxt = S_SCORE;
                    end else begin
                        w_ms_nxt = r_ms_count + 12'd1;
                    end
                end
            end
            S_SCORE: begin
                if (w_press) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

`ifdef BEST_SCORE_EN
    logic [11:0] r_best;

    // Best score only moves on a latched attempt, never on a false start.
    always_ff @(posedge clk) begin
        if (iReset) begin
            r_best <= c_MS_MAX;
        end else if (w_done_nxt && (w_score_nxt < r_best)) begin
            r_best <= w_score_nxt;
        end
    end

    assign io_game.bestScore = r_best;
`endif

    assign io_game.reactScreen  = r_state;
    assign io_game.currentScore = r_score;
    assign io_game.attemptDone  = r_done;
    assign io_game.falseStart   = r_false;

endmodule
`default_nettype wire

// File: tb/tb_reaction_game_fsm.sv
`default_nettype none
// ============================================================================
// Module      : tb_reaction_game_fsm
// Description : Self-checking bench for reaction_game_fsm against a
//               phase/elapsed-time reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reaction_game_fsm;

    localparam int          TPM  = 4;
    localparam int          MIN  = 2;
    localparam int          RB   = 2;
    localparam logic [15:0] SEED = 16'hACE1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    reaction_game_fsm_if u_if ();

    reaction_game_fsm #(
        .TICKS_PER_MS (TPM),
        .MIN_DELAY_MS (MIN),
        .RAND_BITS    (RB),
        .LFSR_SEED    (SEED)
    ) u_dut (
        .clk     (clk),
        .iReset  (rst),
        .io_game (u_if)
    );

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: phase (0 idle, 1 red, 2 green, 3 score) and cycles in phase.
    int          m_phase;
    int          m_c;
    int          m_delay;
    logic        m_prev;
    logic [15:0] m_lfsr;
    int          m_score;
    int          m_best;
    logic        m_done;
    logic        m_fs;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One clock edge of the game rules.
    task automatic model_edge(input logic r, input logic key);
        logic        press;
        logic [15:0] old;
        if (r) begin
            m_phase = 0; m_prev = 1'b1; m_lfsr = SEED; m_score = 0;
            m_best = 4095; m_done = 1'b0; m_fs = 1'b0; m_c = 0;
            return;
        end
        press  = key & ~m_prev;
        m_prev = key;
        m_done = 1'b0;
        m_fs   = 1'b0;
        old    = m_lfsr;
        m_lfsr = {1'b0, m_lfsr[15:1]} ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
        case (m_phase)
            0: if (press) begin
                m_delay = (MIN + int'(old[RB-1:0])) * TPM;
                m_c = 0; m_phase = 1;
            end
            1: begin
                m_c++;
                if (press) begin m_phase = 0; m_fs = 1'b1; end
                else if (m_c == m_delay) begin m_phase = 2; m_c = 0; end
            end
            2: begin
                m_c++;
                if (press) begin
                    m_score = (m_c - 1) / TPM; m_done = 1'b1; m_phase = 3;
                end else if (m_c == 4096 * TPM) begin
                    m_score = 4095; m_done = 1'b1; m_phase = 3;
                end
                if (m_done && m_score < m_best) m_best = m_score;
            end
            default: if (press) m_phase = 0;
        endcase
    endtask

    // Drive one cycle at the falling edge, then compare after the rising edge.
    task automatic cyc(input logic key);
        u_if.keyPress = key;
        model_edge(rst, key);
        @(posedge clk);
        @(negedge clk);
        check("screen", 32'(u_if.reactScreen),  32'(m_phase));
        check("score",  32'(u_if.currentScore), 32'(m_score));
        check("done",   32'(u_if.attemptDone),  32'(m_done));
        check("fstart", 32'(u_if.falseStart),   32'(m_fs));
`ifdef BEST_SCORE_EN
        check("best",   32'(u_if.bestScore),    32'(m_best));
`endif
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0);
    endtask

    task automatic tap();
        cyc(1'b1);
        cyc(1'b0);
    endtask

    task automatic wait_green(input int budget);
        for (int i = 0; i < budget && m_phase != 2; i++) cyc(1'b0);
        check("reach_green", 32'(u_if.reactScreen), 32'd2);
    endtask

    task automatic attempt(input int ms);
        tap();
        wait_green(100);
        run(ms * TPM);
        cyc(1'b1);
        check("attempt_score", 32'(u_if.currentScore), 32'(ms));
        cyc(1'b0);
        tap();
    endtask

    bit seen [0:31];
    int n_distinct;
    int wcyc;

    initial begin
        rst = 1'b1;
        u_if.keyPress = 1'b1;
        @(negedge clk);

        // 1: key held through reset is not a press
        cyc(1'b1);
        cyc(1'b1);
        check("rst_screen", 32'(u_if.reactScreen), 32'd0);
        check("rst_score",  32'(u_if.currentScore), 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) cyc(1'b1);
        check("held_idle", 32'(u_if.reactScreen), 32'd0);
        cyc(1'b0);
        cyc(1'b1);
        check("press_red", 32'(u_if.reactScreen), 32'd1);
        cyc(1'b0);

        // 2: full attempt scoring 37 ms
        wait_green(100);
        run(37 * TPM);
        cyc(1'b1);
        check("score37",   32'(u_if.currentScore), 32'd37);
        check("done37",    32'(u_if.attemptDone),  32'd1);
        check("screen_sc", 32'(u_if.reactScreen),  32'd3);
        cyc(1'b0);
        check("done_pulse", 32'(u_if.attemptDone), 32'd0);
        tap();
        check("back_idle", 32'(u_if.reactScreen),  32'd0);
        check("keep37",    32'(u_if.currentScore), 32'd37);

        // 3: false starts, including press on the expiry cycle
        cyc(1'b1);
        cyc(1'b0);
        cyc(1'b0);
        cyc(1'b1);
        check("fs_pulse",  32'(u_if.falseStart),   32'd1);
        check("fs_idle",   32'(u_if.reactScreen),  32'd0);
        check("fs_score",  32'(u_if.currentScore), 32'd37);
        cyc(1'b0);
        check("fs_once",   32'(u_if.falseStart),   32'd0);
        cyc(1'b1);
        cyc(1'b0);
        for (int i = 0; i < 100 && !(m_phase == 1 && m_c == m_delay - 1); i++) cyc(1'b0);
        cyc(1'b1);
        check("fs_expiry", 32'(u_if.falseStart),   32'd1);
        check("fs_exp_sc", 32'(u_if.reactScreen),  32'd0);
        cyc(1'b0);

        // 4: timeout saturates at 4095
        tap();
        wait_green(100);
        run(4096 * TPM - 1);
        check("pre_timeout", 32'(u_if.reactScreen), 32'd2);
        cyc(1'b0);
        check("to_score",  32'(u_if.currentScore), 32'd4095);
        check("to_done",   32'(u_if.attemptDone),  32'd1);
        check("to_screen", 32'(u_if.reactScreen),  32'd3);
        cyc(1'b0);
        tap();

        // 5: randomized attempts, red-phase length within range
        for (int k = 0; k < 32; k++) seen[k] = 1'b0;
        for (int a = 0; a < 50; a++) begin
            cyc(1'b1);
            wcyc = 0;
            for (int i = 0; i < 100 && u_if.reactScreen == 2'd1; i++) begin
                wcyc++;
                cyc(1'b0);
            end
            check("wait_range", 32'(wcyc >= MIN * TPM && wcyc <= (MIN + 3) * TPM), 32'd1);
            if (wcyc < 32) seen[wcyc] = 1'b1;
            wait_green(10);
            run($urandom_range(0, 40));
            tap();
            tap();
            run($urandom_range(0, 7));
        end
        n_distinct = 0;
        for (int k = 0; k < 32; k++) if (seen[k]) n_distinct++;
        check("distinct", 32'(n_distinct >= 2), 32'd1);

        // 6: best score tracking and reset mid-green
        rst = 1'b1;
        cyc(1'b0);
        rst = 1'b0;
        cyc(1'b0);
`ifdef BEST_SCORE_EN
        check("best_rst", 32'(u_if.bestScore), 32'd4095);
        attempt(120);
        check("best120", 32'(u_if.bestScore), 32'd120);
        attempt(85);
        check("best85",  32'(u_if.bestScore), 32'd85);
        cyc(1'b1);
        cyc(1'b0);
        cyc(1'b1);
        cyc(1'b0);
        check("best_fs", 32'(u_if.bestScore), 32'd85);
        attempt(300);
        check("best300", 32'(u_if.bestScore), 32'd85);
`else
        attempt(120);
        attempt(85);
`endif
        tap();
        wait_green(100);
        run(10);
        rst = 1'b1;
        cyc(1'b0);
        rst = 1'b0;
        check("midrst_screen", 32'(u_if.reactScreen),  32'd0);
        check("midrst_score",  32'(u_if.currentScore), 32'd0);
`ifdef BEST_SCORE_EN
        check("midrst_best",   32'(u_if.bestScore),    32'd4095);
`endif
        run(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
